// File: rtl/uart_core_param.sv
// uart_core_param: single-clock UART transceiver with internal baud tick, ready/valid TX and majority-vote RX
module uart_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int DIV_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DIV_W-1:0]      baud_div,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam logic [DIV_W-1:0]      D1 = 1;
    localparam logic [PRESCALE_W-1:0] P1 = 1;
    localparam logic [3:0]            DW = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    logic [DIV_W-1:0]      tick_cnt, div_max;
    logic                  tick;
    tx_state_t             tx_state, tx_next;
    logic [PRESCALE_W-1:0] tx_ps, tx_tcnt;
    logic                  tx_pe, tx_s2, tx_par, tx_end, tx_obit;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [3:0]            tx_bit;
    rx_state_t             rx_state, rx_next;
    logic [1:0]            rx_sync;
    logic                  rx_s, rx_pe, rx_pt, rx_pbit, smp_a, smp_b, vote, rx_vote, rx_end, stop_v, perr;
    logic [PRESCALE_W-1:0] rx_ps, rx_tcnt, rx_half;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [3:0]            rx_cnt;

    assign div_max = (baud_div == '0) ? D1 : baud_div;
    assign tick    = tick_cnt >= div_max - D1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) tick_cnt <= '0;
        else      tick_cnt <= tick ? '0 : tick_cnt + D1;
    end

    assign tx_end   = tick && tx_tcnt == tx_ps - P1;
    assign tx_ready = tx_state == TX_IDLE;
    assign busy     = !tx_ready;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  tx_next = tx_valid ? TX_WAIT : TX_IDLE;
            TX_WAIT:  tx_next = tick ? TX_START : TX_WAIT;
            TX_START: tx_next = tx_end ? TX_DATA : TX_START;
            TX_DATA:  tx_next = (tx_end && tx_bit == DW - 4'd1) ? (tx_pe ? TX_PAR : TX_STOP1) : TX_DATA;
            TX_PAR:   tx_next = tx_end ? TX_STOP1 : TX_PAR;
            TX_STOP1: tx_next = tx_end ? (tx_s2 ? TX_STOP2 : TX_IDLE) : TX_STOP1;
            TX_STOP2: tx_next = tx_end ? TX_IDLE : TX_STOP2;
            default:  tx_next = TX_IDLE;
        endcase
        // the shift happens on the same edge, so the next data bit is tx_sh[1]
        tx_obit = tx_next == TX_START ? 1'b0 :
                  tx_next == TX_DATA  ? ((tx_state == TX_DATA && tx_end) ? tx_sh[1] : tx_sh[0]) :
                  tx_next == TX_PAR   ? tx_par : 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state <= TX_IDLE;
            tx_out   <= 1'b1;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_tcnt  <= '0;
            tx_ps    <= '0;
            tx_pe    <= 1'b0;
            tx_s2    <= 1'b0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_out   <= tx_obit;
            if (tx_state == TX_IDLE && tx_valid) begin
                tx_sh  <= tx_data;
                tx_par <= ^tx_data ^ par_typ;
                tx_pe  <= par_en;
                tx_s2  <= stop2;
                tx_ps  <= prescale;
            end
            if (tx_state == TX_START) tx_bit <= '0;
            if (tx_state == TX_DATA && tx_end) begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 4'd1;
            end
            if (tick) tx_tcnt <= (tx_state == TX_WAIT || tx_end) ? '0 : tx_tcnt + P1;
        end
    end

    assign rx_s    = rx_sync[1];
    assign rx_half = rx_ps >> 1;
    assign rx_vote = tick && rx_tcnt == rx_half + P1;
    assign rx_end  = tick && rx_tcnt == rx_ps - P1;
    assign vote    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign stop_v  = rx_vote && rx_state == RX_STOP;
    assign perr    = rx_pe && (rx_pbit != (^rx_sh ^ rx_pt));

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  rx_next = rx_s ? RX_IDLE : RX_START;
            RX_START: rx_next = (rx_vote && vote) ? RX_IDLE : rx_end ? RX_DATA : RX_START;
            RX_DATA:  rx_next = (rx_end && rx_cnt == DW) ? (rx_pe ? RX_PAR : RX_STOP) : RX_DATA;
            RX_PAR:   rx_next = rx_end ? RX_STOP : RX_PAR;
            RX_STOP:  rx_next = rx_vote ? RX_IDLE : RX_STOP;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_cnt   <= '0;
            rx_ps    <= '0;
            rx_pe    <= 1'b0;
            rx_pt    <= 1'b0;
            rx_pbit  <= 1'b0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            par_err  <= 1'b0;
            stp_err  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx_in};
            rx_state <= rx_next;
            // config tracks the inputs while idle, freezing at the start edge
            if (rx_state == RX_IDLE) begin
                rx_tcnt <= '0;
                rx_cnt  <= '0;
                rx_ps   <= prescale;
                rx_pe   <= par_en;
                rx_pt   <= par_typ;
            end else if (tick) begin
                rx_tcnt <= rx_end ? '0 : rx_tcnt + P1;
            end
            if (tick && rx_tcnt == rx_half - P1) smp_a <= rx_s;
            if (tick && rx_tcnt == rx_half) smp_b <= rx_s;
            if (rx_vote && rx_state == RX_DATA) begin
                rx_sh  <= {vote, rx_sh[DATA_WIDTH-1:1]};
                rx_cnt <= rx_cnt + 4'd1;
            end
            if (rx_vote && rx_state == RX_PAR) rx_pbit <= vote;
            rx_valid <= stop_v && vote && !perr;
            par_err  <= stop_v && perr;
            stp_err  <= stop_v && !vote;
            if (stop_v && vote && !perr) rx_data <= rx_sh;
        end
    end
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: table-driven RX vectors with a scoreboard, plus TX, loopback, reset and width-5 sequences
module tb_uart_core_param;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [5:0]  prescale = 6'd8;
    logic        par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_out, busy, rx_in, rx_valid, par_err, stp_err;
    logic [7:0]  rx_data;
    logic        rx_drv = 1'b1, loop = 1'b0;
    logic [4:0]  tx_data5 = 5'h00, rx_data5;
    logic        tx_valid5 = 1'b0;
    logic        tx_ready5, tx_out5, busy5, rx_valid5, par_err5, stp_err5;

    always #5 CLK = ~CLK;
    assign rx_in = loop ? tx_out : rx_drv;

    uart_core_param #(.DATA_WIDTH(8)) u8 (
        .CLK(CLK), .RST(RST), .baud_div(baud_div), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy),
        .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid), .par_err(par_err), .stp_err(stp_err));

    uart_core_param #(.DATA_WIDTH(5)) u5 (
        .CLK(CLK), .RST(RST), .baud_div(baud_div), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
        .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(tx_ready5), .tx_out(tx_out5), .busy(busy5),
        .rx_in(tx_out5), .rx_data(rx_data5), .rx_valid(rx_valid5), .par_err(par_err5), .stp_err(stp_err5));

    typedef struct packed {logic v, pe, se; logic [7:0] d;} rx_exp_t;
    typedef struct packed {logic [7:0] d; logic pe, pt, pbit, stop, v, perr, serr; logic [7:0] exp_d;} vec_t;

    rx_exp_t rx_q[$];
    logic    tx_q[$];
    longint  ev_time[$];
    rx_exp_t mon_e;
    vec_t    vecs[8];
    logic [7:0] lb[3];
    int      checks = 0, errors = 0, ev_cnt = 0, e5 = 0;
    int      bad, w, bc, k, n0, t0;
    longint  cyc = 0, gap;
    logic    exp_bit;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic rx_bit(input logic b);
        rx_drv = b;
        repeat (32) @(negedge CLK);
    endtask

    task automatic rx_frame(input vec_t t);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(t.d[i]);
        if (t.pe) rx_bit(t.pbit);
        rx_bit(t.stop);
        rx_drv = 1'b1;
    endtask

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (RST && (rx_valid || par_err || stp_err)) begin
            ev_cnt++;
            ev_time.push_back(cyc);
            if (rx_q.size() == 0) begin
                chk("rx unexpected event", {29'b0, rx_valid, par_err, stp_err}, 32'd0);
            end else begin
                mon_e = rx_q.pop_front();
                chk("rx flags", {29'b0, rx_valid, par_err, stp_err}, {29'b0, mon_e.v, mon_e.pe, mon_e.se});
                chk("rx data", {24'b0, rx_data}, {24'b0, mon_e.d});
            end
        end
        if (RST && (par_err5 || stp_err5)) e5++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = {8'h3C, 7'b1001100, 8'h3C};
        vecs[1] = {8'hA5, 7'b1011010, 8'h3C};
        vecs[2] = {8'hA5, 7'b1001100, 8'hA5};
        vecs[3] = {8'h5A, 7'b1111100, 8'h5A};
        vecs[4] = {8'hC3, 7'b0000001, 8'h5A};
        vecs[5] = {8'h01, 7'b1110011, 8'h5A};
        vecs[6] = {8'h00, 7'b0001100, 8'h00};
        vecs[7] = {8'hFF, 7'b1001100, 8'hFF};
        lb[0] = 8'h3C; lb[1] = 8'hFF; lb[2] = 8'h00;

        repeat (3) @(negedge CLK);
        chk("reset tx_out", {31'b0, tx_out}, 32'd1);
        chk("reset tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset rx_data", {24'b0, rx_data}, 32'd0);
        RST = 1'b1;
        bad = 0;
        repeat (500) begin
            @(negedge CLK);
            if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle outputs", bad, 0);
        chk("idle rx events", ev_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            par_en  = vecs[i].pe;
            par_typ = vecs[i].pt;
            rx_q.push_back({vecs[i].v, vecs[i].perr, vecs[i].serr, vecs[i].exp_d});
            rx_frame(vecs[i]);
            repeat (64) @(negedge CLK);
        end
        chk("rx vector events", ev_cnt, 8);
        chk("rx queue drained", rx_q.size(), 0);

        n0 = ev_cnt;
        rx_drv = 1'b0;
        repeat (8) @(negedge CLK);
        rx_drv = 1'b1;
        repeat (128) @(negedge CLK);
        chk("glitch no event", ev_cnt, n0);
        chk("glitch rx_data kept", {24'b0, rx_data}, 32'hFF);

        par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(exp_bit_of(8'hA5, i));
        tx_q.push_back(^8'hA5 ^ 1'b0);
        tx_q.push_back(1'b1);
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        chk("tx_ready after accept", {31'b0, tx_ready}, 32'd0);
        chk("busy after accept", {31'b0, busy}, 32'd1);
        w = 0; bc = 0;
        while (tx_out !== 1'b0 && w < 64) begin
            if (busy) bc++;
            w++;
            @(negedge CLK);
        end
        chk("tx start seen", {31'b0, tx_out}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            exp_bit = tx_q.pop_front();
            bad = 0;
            repeat (32) begin
                if (tx_out !== exp_bit) bad++;
                if (busy) bc++;
                @(negedge CLK);
            end
            chk($sformatf("tx bit %0d wrong cycles", i), bad, 0);
        end
        chk("tx idle after frame", {31'b0, tx_out}, 32'd1);
        chk("busy after frame", {31'b0, busy}, 32'd0);
        chk("tx_ready after frame", {31'b0, tx_ready}, 32'd1);
        chk("busy frame cycles", bc - w, 352);

        loop = 1'b1; stop2 = 1'b1; par_en = 1'b1; par_typ = 1'b0;
        repeat (64) @(negedge CLK);
        n0 = ev_cnt; t0 = ev_time.size();
        for (int i = 0; i < 3; i++) begin
            tx_data = lb[i]; tx_valid = 1'b1;
            k = 0;
            while (!tx_ready && k < 1000) begin
                @(negedge CLK);
                k++;
            end
            chk("loopback accept in time", {31'b0, tx_ready}, 32'd1);
            rx_q.push_back({3'b100, lb[i]});
            @(negedge CLK);
        end
        tx_valid = 1'b0;
        k = 0;
        while (ev_cnt < n0 + 3 && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        chk("loopback events", ev_cnt, n0 + 3);
        if (ev_time.size() >= t0 + 3) begin
            for (int i = 0; i < 2; i++) begin
                gap = ev_time[t0 + i + 1] - ev_time[t0 + i];
                chk($sformatf("loopback back-to-back gap %0d (%0d cycles)", i, gap), {31'b0, gap >= 384 && gap <= 388}, 32'd1);
            end
        end
        repeat (128) @(negedge CLK);
        loop = 1'b0; stop2 = 1'b0;

        par_en = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        k = 0;
        while (tx_out !== 1'b0 && k < 64) begin
            @(negedge CLK);
            k++;
        end
        repeat (32 * 3 + 5) @(negedge CLK);
        chk("tx mid data low", {31'b0, tx_out}, 32'd0);
        RST = 1'b0;
        #1;
        chk("async reset tx_out", {31'b0, tx_out}, 32'd1);
        chk("async reset tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("async reset busy", {31'b0, busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("post reset tx_out", {31'b0, tx_out}, 32'd1);
        chk("post reset busy", {31'b0, busy}, 32'd0);

        par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
        tx_data5 = 5'h15; tx_valid5 = 1'b1;
        @(negedge CLK);
        tx_valid5 = 1'b0;
        k = 0;
        while (tx_out5 !== 1'b0 && k < 64) begin
            @(negedge CLK);
            k++;
        end
        repeat (6 * 32 + 16) @(negedge CLK);
        chk("dw5 odd parity bit", {31'b0, tx_out5}, {31'b0, ^5'h15 ^ 1'b1});
        k = 0;
        while (!rx_valid5 && k < 400) begin
            @(negedge CLK);
            k++;
        end
        chk("dw5 rx_valid", {31'b0, rx_valid5}, 32'd1);
        chk("dw5 rx_data", {27'b0, rx_data5}, 32'h15);
        repeat (64) @(negedge CLK);
        chk("dw5 no error pulses", e5, 0);
        chk("final queue empty", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic exp_bit_of(input logic [7:0] d, input int i);
        return d[i];
    endfunction
endmodule
